// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: default address width and Gray/binary conversions.
package async_fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int PTR_MAX      = 32;

  typedef logic [PTR_MAX-1:0] ptr_word_t;

  function automatic ptr_word_t width_mask(input int width);
    ptr_word_t m;
    m = '0;
    for (int i = 0; i < PTR_MAX; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int width);
    ptr_word_t b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB, done as a log-depth shift cascade.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int width);
    ptr_word_t b;
    b = gray & width_mask(width);
    for (int s = 1; s < PTR_MAX; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_lvl_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty flag and fill level of the async FIFO (rclk domain).
// Optional sticky underflow flag is built when RPTR_UNDERFLOW_FLAG_EN is defined.
module rptr_empty_lvl
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE  = ADDRSIZE_DEF,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rempty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;
  logic          accept;
  ptr_word_t     gray_word;

  gray2bin #(.WIDTH(PW)) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin_s)
  );

  assign accept     = rinc & ~rempty;
  assign rbinnext   = rbin + PW'(accept);
  assign gray_word  = bin2gray(ptr_word_t'(rbinnext), PW);
  assign rgraynext  = gray_word[PW-1:0];
  // Modulo subtraction; the write side never runs more than one depth ahead.
  assign level_next = wbin_s - rbinnext;
  assign raddr      = rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == rq2_wptr);
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= AE_LIMIT);
    end
  end

`ifdef RPTR_UNDERFLOW_FLAG_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rinc && rempty) begin
      runderflow <= 1'b1;
    end
  end
`else
  assign runderflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Scoreboard bench for rptr_empty_lvl: stimulus pushes expected outputs, a monitor pops and compares after each rclk edge.
module tb_rptr_empty_lvl;

  localparam int ADDRSIZE  = 4;
  localparam int AE_THRESH = 2;
  localparam int DEPTH     = 1 << ADDRSIZE;
  localparam int PMOD      = 2 * DEPTH;

  logic                rclk;
  logic                rrst_n;
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic                rempty;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   rlevel;
  logic                ralmost_empty;
  logic                runderflow;

  rptr_empty_lvl #(.ADDRSIZE(ADDRSIZE), .AE_THRESH(AE_THRESH)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rempty        (rempty),
    .raddr         (raddr),
    .rptr          (rptr),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty),
    .runderflow    (runderflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic                e;
    logic [ADDRSIZE:0]   lvl;
    logic                ae;
    logic [ADDRSIZE-1:0] addr;
    logic [ADDRSIZE:0]   ptr;
    logic                uf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: counts of words written (as seen) and read, plus sticky misuse flag.
  int m_wr, m_rd, m_lvl;
  bit m_uf;

  function automatic logic [ADDRSIZE:0] to_gray(input int v);
    return (ADDRSIZE+1)'(v ^ (v >> 1));
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_lvl = 0; m_uf = 0;
  endtask

  task automatic step(input bit inc, input int wr_new);
    exp_t x;
    bit   acc;
    @(negedge rclk);
    rinc     = inc;
    m_wr     = wr_new % PMOD;
    rq2_wptr = to_gray(m_wr);
    acc = inc && (m_lvl != 0);
    if (inc && m_lvl == 0) m_uf = 1;
    if (acc) m_rd = (m_rd + 1) % PMOD;
    m_lvl  = (m_wr - m_rd + PMOD) % PMOD;
    x.e    = (m_lvl == 0);
    x.lvl  = (ADDRSIZE+1)'(m_lvl);
    x.ae   = (m_lvl <= AE_THRESH);
    x.addr = ADDRSIZE'(m_rd % DEPTH);
    x.ptr  = to_gray(m_rd);
`ifdef RPTR_UNDERFLOW_FLAG_EN
    x.uf   = m_uf;
`else
    x.uf   = 1'b0;
`endif
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rinc     = 1'b0;
    rq2_wptr = '0;
    rrst_n   = 1'b0;
    model_reset();
    #1;
    check("reset_rempty", int'(rempty), 1);
    check("reset_rptr", int'(rptr), 0);
    check("reset_raddr", int'(raddr), 0);
    check("reset_rlevel", int'(rlevel), 0);
    check("reset_ralmost_empty", int'(ralmost_empty), 1);
    check("reset_runderflow", int'(runderflow), 0);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // Monitor: the block presents fresh outputs every rclk; compare after each edge.
  always @(posedge rclk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check("rempty", int'(rempty), int'(x.e));
      check("rlevel", int'(rlevel), int'(x.lvl));
      check("ralmost_empty", int'(ralmost_empty), int'(x.ae));
      check("raddr", int'(raddr), int'(x.addr));
      check("rptr", int'(rptr), int'(x.ptr));
      check("runderflow", int'(runderflow), int'(x.uf));
    end
  end

  initial begin
    int adv, room;
    rrst_n   = 1'b0;
    rinc     = 1'b0;
    rq2_wptr = '0;
    model_reset();
    do_reset();

    // Three entries appear, read them out, then one read too many.
    step(0, 3);
    step(1, 3);
    step(1, 3);
    step(1, 3);
    step(1, 3);
    step(0, 3);

    // Full FIFO right after reset.
    do_reset();
    step(0, 16);
    step(0, 16);

    // 32 interleaved writes and reads across the pointer wrap.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(0, m_wr + 1);
      step(1, m_wr);
    end
    step(0, m_wr);

    // Randomized traffic, with the write side never more than one depth ahead.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      room = DEPTH - ((m_wr - m_rd + PMOD) % PMOD);
      adv  = $urandom_range(0, 2);
      if (adv > room) adv = room;
      step(($urandom_range(0, 3) != 0), m_wr + adv);
    end
    step(0, m_wr);

    @(negedge rclk);
    @(negedge rclk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rptr_empty_lvl.md
# rptr_empty_lvl

Read-side pointer, empty-flag and occupancy block of the asynchronous FIFO, in the read clock domain. Consumes the 2-flop-synchronized Gray write pointer from the write domain and advances the read pointer on accepted reads. It drives the memory read address and the Gray read pointer that is synchronized back to the write side. Beyond the basic empty test, it reports a registered fill level and an almost-empty flag for read-side flow control.

## Interface
- ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE entries; pointers are ADDRSIZE+1 bits.
- AE_THRESH, 2, almost-empty threshold in entries; legal range 0..2^ADDRSIZE.

Ports:
- rclk  input  1  read clock; all state updates on its rising edge.
- rrst_n  input  1  asynchronous, active-low reset.
- rinc  input  1  read request; accepted only when rempty=0.
- rq2_wptr  input  ADDRSIZE+1  write pointer (Gray), already synchronized into rclk.
- rempty  output  1  FIFO empty, registered.
- raddr  output  ADDRSIZE  memory read address (binary).
- rptr  output  ADDRSIZE+1  read pointer (Gray), registered, to write-side synchronizer.
- rlevel  output  ADDRSIZE+1  occupancy seen from read side, 0..2^ADDRSIZE, registered.
- ralmost_empty  output  1  rlevel <= AE_THRESH, registered.
- runderflow  output  1  sticky underflow flag (see Configuration).

## Operation
- State: rbin and rptr (ADDRSIZE+1 each), rempty, rlevel, ralmost_empty, runderflow.
- rbinnext = rbin + (rinc & ~rempty). rgraynext = (rbinnext>>1) ^ rbinnext.
- Each rclk: rbin<=rbinnext, rptr<=rgraynext.
- raddr = rbin[ADDRSIZE-1:0]. Binary addressing of memory is intended.
- wbin_s = Gray-to-binary of rq2_wptr (combinational XOR prefix from MSB).
- Empty: rempty <= (rgraynext == rq2_wptr).
- Level: rlevel <= (wbin_s - rbinnext), computed modulo 2^(ADDRSIZE+1). The result is never above 2^ADDRSIZE.
- Almost-empty: ralmost_empty <= (wbin_s - rbinnext) <= AE_THRESH.
- Invariant: rempty=1 exactly when rlevel=0. Both flags derive from the same next-state values.
- rinc while rempty=1: ignored. rbin, rptr and raddr hold.
- Wrap-around: rbin wraps from 2^(ADDRSIZE+1)-1 to 0. The MSB toggles and rptr stays single-bit-changing.
- Full FIFO (write pointer 2^ADDRSIZE ahead): rlevel = 2^ADDRSIZE and rempty=0.
- Simultaneous read accept and write-pointer advance: the level uses both new values. The net change is (writes seen) − 1.
- Level and flags are pessimistic because of synchronizer lag. They may under-report occupancy but never over-report it.

## Timing
- Reset (asserted, async): rbin=0, rptr=0, raddr=0, rempty=1, rlevel=0, ralmost_empty=1 (0 if AE_THRESH... always 1 since 0<=AE_THRESH), runderflow=0.
- Reset deassertion mid-operation is handled by the reset-synchronizer wrapper; this block only requires rrst_n to be async-assert safe.
- rempty, rlevel and ralmost_empty update 1 rclk after a change on rq2_wptr. End-to-end write-to-not-empty is 3 rclk, counting the synchronizer.
- Accepted read: raddr and rptr advance at the same edge. rempty asserts at that edge if the last entry was read; no extra cycle.
- Read data handshake: the memory presents data for raddr combinationally. The consumer samples it in the cycle it asserts rinc with rempty=0.

## Configuration
- RPTR_UNDERFLOW_FLAG_EN defined: runderflow is set on any rclk edge where rinc=1 and rempty=1. It stays set until rrst_n asserts.
- Not defined: runderflow is tied to 0 and no flop is inferred. Pointer behaviour is identical either way.

## Structure
- Shared package async_fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized by width.
  - The default ADDRSIZE constant, used by both pointer blocks and the synchronizers.
- One sub-module: gray2bin (combinational, parameterized width), instanced on rq2_wptr.

## Test plan
- Reset, ADDRSIZE=4, AE_THRESH=2 -> rempty=1, rptr=0, raddr=0, rlevel=0, ralmost_empty=1, runderflow=0.
- rq2_wptr=5'b00010 (binary 3), rinc=0 -> after 1 rclk: rempty=0, rlevel=3, ralmost_empty=0.
- Same state, one rinc pulse -> raddr=1, rptr=5'b00001, rlevel=2, ralmost_empty=1.
- Two more reads -> rempty=1 and rlevel=0 at the edge of the 3rd read. A further rinc leaves raddr=3, and sets runderflow=1 only with the macro defined.
- rq2_wptr=5'b11000 (binary 16) with rbin=0 -> rlevel=16, rempty=0, ralmost_empty=0.
- Drive 32 writes and 32 reads interleaved -> rbin wraps 31->0, rptr goes 5'b10000->5'b00000, and rempty=1 with rlevel=0 at the end.
